// File: rtl/vtp_xlate_ctrl.sv
// vtp_xlate_ctrl: round-robin sequencer for the shared virtual-to-physical
// decode tree. It accepts one translation request at a time and holds the
// decoder input for the decoder latency. It then returns the result on a
// valid/ready channel. It also keeps the SCBs frozen while a translation is
// in flight by granting the bitmap updater only from IDLE.
//
//   state | meaning
//   IDLE  | free; the updater wins over requesters, otherwise round-robin accept
//   DEC   | o_dec_vaddr held while the decode tree settles (lat_cnt down-counter)
//   RSP   | response presented until i_rsp_ready
//   UPD   | SCBs owned by the updater until i_upd_done
module vtp_xlate_ctrl #(
  parameter  int BITMAP  = 128,
  parameter  int NREQ    = 4,
  parameter  int DEC_LAT = 1,
  localparam int ADDR_W  = $clog2(BITMAP),
  localparam int ID_W    = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ*ADDR_W-1:0]   i_req_vaddr,
  output logic [NREQ-1:0]          o_req_ready,
  output logic                     o_rsp_valid,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [ADDR_W-1:0]        o_rsp_paddr,
  output logic                     o_rsp_fault,
  input  logic                     i_rsp_ready,
  output logic [ADDR_W-1:0]        o_dec_vaddr,
  input  logic [ADDR_W-1:0]        i_dec_paddr,
  input  logic                     i_dec_fault,
  input  logic                     i_upd_req,
  output logic                     o_upd_gnt,
  input  logic                     i_upd_done
);

  localparam int LAT_W = (DEC_LAT > 1) ? $clog2(DEC_LAT) : 1;

  typedef enum logic [1:0] {IDLE, DEC, RSP, UPD} state_t;

  state_t              state_q;
  logic [ID_W-1:0]     last_gnt_q;
  logic [LAT_W-1:0]    lat_cnt_q;
  logic [ADDR_W-1:0]   dec_vaddr_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [ADDR_W-1:0]   rsp_paddr_q;
  logic                rsp_fault_q;
  logic                rsp_valid_q;
  logic                upd_gnt_q;

  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic [ID_W-1:0]     cand;
  logic [ADDR_W-1:0]   win_vaddr;
  logic                accept;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = last_gnt_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == ID_W'(NREQ - 1)) ? '0 : cand + ID_W'(1);
      if (!win_found && i_req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Accept decision and the winner's address; ready is suppressed during reset
  // so that no request is lost to a handshake the controller then discards.
  always_comb begin
    accept    = (state_q == IDLE) && !rst && !i_upd_req && win_found;
    win_vaddr = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (win_idx == ID_W'(r)) win_vaddr = i_req_vaddr[r*ADDR_W +: ADDR_W];
      o_req_ready[r] = accept && (win_idx == ID_W'(r));
    end
  end

  // Sequencer: arbitration, decoder hold, response hand-off and update interlock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= ID_W'(NREQ - 1);
      lat_cnt_q   <= '0;
      dec_vaddr_q <= '0;
      rsp_id_q    <= '0;
      rsp_paddr_q <= '0;
      rsp_fault_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      upd_gnt_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_upd_req) begin
            state_q   <= UPD;
            upd_gnt_q <= 1'b1;
          end else if (accept) begin
            state_q     <= DEC;
            dec_vaddr_q <= win_vaddr;
            rsp_id_q    <= win_idx;
            last_gnt_q  <= win_idx;
            lat_cnt_q   <= LAT_W'(DEC_LAT - 1);
          end
        end
        DEC: begin
          if (lat_cnt_q == '0) begin
            rsp_paddr_q <= i_dec_paddr;
            rsp_fault_q <= i_dec_fault;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end
        end
        RSP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        UPD: begin
          if (i_upd_done) begin
            upd_gnt_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_paddr = rsp_paddr_q;
  assign o_rsp_fault = rsp_fault_q;
  assign o_dec_vaddr = dec_vaddr_q;
  assign o_upd_gnt   = upd_gnt_q;

endmodule
